load_store_unit: RTL

- MEM-stage load/store unit between the pipeline and a handshaked data-memory bus.
- Issues one word-aligned bus transaction per access, with byte enables and lane-replicated store data.
- Right-aligns load data into bits [7:0]/[15:0]/[31:0].
- Hands aligned data plus extension select to the downstream load sign-extender; stalls the pipeline while the bus is busy.

---
 rtl/load_store_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one aligned bus transaction per access, load right-align.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and flag misalign.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              stall,
  output logic [31:0]       DDT_from_mem,
  output logic [1:0]        read_ext_src,
  output logic              rdata_valid,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
`ifdef MISALIGN_TRAP_EN
  ,output logic             misalign
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lo_q, lo_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       ddt_q, ddt_d;
  logic [1:0]        ext_q, ext_d;

  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [1:0]  off_c;
  logic [31:0] sh_c;
  logic [31:0] ld_c;
  logic        trap_c;

`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign trap_c = (mem_size == 2'b10 && mem_addr[0])
               || ((mem_size == 2'b00 || mem_size == 2'b11)
                   && mem_addr[1:0] != 2'b00);
`else
  assign trap_c = 1'b0;
`endif

  // Store lanes and enables from the incoming request
  always_comb begin
    be_c = 4'hF;
    wd_c = mem_wdata;
    if (mem_we) begin
      unique case (1'b1)
        mem_size == 2'b01: begin
          be_c = 4'b0001 << mem_addr[1:0];
          wd_c = {4{mem_wdata[7:0]}};
        end
        mem_size == 2'b10: begin
          be_c = mem_addr[1] ? 4'b1100 : 4'b0011;
          wd_c = {2{mem_wdata[15:0]}};
        end
        default: begin
          be_c = 4'hF;
          wd_c = mem_wdata;
        end
      endcase
    end
  end

  // Effective lane offset: half drops addr[0], word drops both bits
  always_comb begin
    off_c = 2'b00;
    ld_c  = 32'h0;
    unique case (1'b1)
      size_q == 2'b01: off_c = lo_q;
      size_q == 2'b10: off_c = {lo_q[1], 1'b0};
      default:         off_c = 2'b00;
    endcase
    sh_c = bus_rdata >> {off_c, 3'b000};
    unique case (1'b1)
      size_q == 2'b01: ld_c = {24'h0, sh_c[7:0]};
      size_q == 2'b10: ld_c = {16'h0, sh_c[15:0]};
      default:         ld_c = sh_c;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    lo_d    = lo_q;
    req_d   = req_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    ddt_d   = ddt_q;
    ext_d   = ext_q;
    stall   = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          stall  = 1'b1;
          we_d   = mem_we;
          size_d = mem_size;
          lo_d   = mem_addr[1:0];
          addr_d = {mem_addr[ADDR_W-1:2], 2'b00};
          be_d   = be_c;
          wd_d   = wd_c;
          if (trap_c) begin
            state_d = DONE;
            ddt_d   = 32'h0;
`ifdef MISALIGN_TRAP_EN
            mis_d   = 1'b1;
`endif
          end else begin
            state_d = BUSY;
            req_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (bus_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          ext_d   = (size_q == 2'b11) ? 2'b00 : size_q;
          if (!we_q) ddt_d = ld_c;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      lo_q    <= 2'b00;
      req_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'h0;
      wd_q    <= 32'h0;
      ddt_q   <= 32'h0;
      ext_q   <= 2'b00;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      lo_q    <= lo_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      ddt_q   <= ddt_d;
      ext_q   <= ext_d;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign bus_req      = req_q;
  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_be       = be_q;
  assign bus_wdata    = wd_q;
  assign DDT_from_mem = ddt_q;
  assign read_ext_src = ext_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign     = mis_q;
  assign rdata_valid  = (state_q == DONE) && !we_q && !mis_q;
`else
  assign rdata_valid  = (state_q == DONE) && !we_q;
`endif

endmodule
